// File: rtl/adder_pkg.sv
// Shared types and elaboration checks for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic [0:0] {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module adder_slice
    import adder_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [SW:0] c_s;

    // Full-adder chain across the slice
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = ci;
        for (int i = 0; i < SW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c_s[SW];
    assign c_msb = c_s[SW-1];

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple adder/subtractor: one SW-bit slice per stage, carries and
// operands skewed forward, finished low slices deskewed alongside.
module pipelined_adder_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int  SW        = WIDTH / STAGES;
    localparam int  LAST      = STAGES - 1;
    localparam bit  PARAMS_OK = params_ok(WIDTH, STAGES);

    if (!PARAMS_OK) begin : g_bad_params
        $fatal(1, "pipelined_adder_sub: WIDTH must be a non-zero multiple of STAGES");
    end

    op_e              op_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic             in_ready_s;

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] carry_r;
    logic              ovf_r;

    logic [WIDTH-1:0] a_r       [STAGES];
    logic [WIDTH-1:0] b_r       [STAGES];
    logic [WIDTH-1:0] res_r     [STAGES];
    logic [WIDTH-1:0] a_in_s    [STAGES];
    logic [WIDTH-1:0] b_in_s    [STAGES];
    logic [WIDTH-1:0] res_nxt_s [STAGES];

    logic [WIDTH-1:0]  sl_a_s;
    logic [WIDTH-1:0]  sl_b_s;
    logic [WIDTH-1:0]  sl_sum_s;
    logic [STAGES-1:0] sl_ci_s;
    logic [STAGES-1:0] sl_co_s;
    logic              sl_cmsb_s [STAGES];

    // Operation decode: subtract is a + ~b + !cin, inversion travels with b
    always_comb begin
        op_s      = op_e'(sub);
        b_eff_s   = (op_s == OP_SUB) ? ~b : b;
        cin_eff_s = (op_s == OP_SUB) ? ~cin : cin;
    end

    // Per-stage operand sources and slice inputs
    always_comb begin
        a_in_s[0]  = a;
        b_in_s[0]  = b_eff_s;
        sl_ci_s    = '0;
        sl_ci_s[0] = cin_eff_s;
        for (int k = 1; k < STAGES; k++) begin
            a_in_s[k]  = a_r[k-1];
            b_in_s[k]  = b_r[k-1];
            sl_ci_s[k] = carry_r[k-1];
        end
        sl_a_s = '0;
        sl_b_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl_a_s[k*SW +: SW] = a_in_s[k][k*SW +: SW];
            sl_b_s[k*SW +: SW] = b_in_s[k][k*SW +: SW];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.SW(SW)) u_slice (
            .a     (sl_a_s[k*SW +: SW]),
            .b     (sl_b_s[k*SW +: SW]),
            .ci    (sl_ci_s[k]),
            .s     (sl_sum_s[k*SW +: SW]),
            .co    (sl_co_s[k]),
            .c_msb (sl_cmsb_s[k])
        );
    end

    // Deskew: each stage appends its fresh slice to the lower result bits
    always_comb begin
        res_nxt_s[0]         = '0;
        res_nxt_s[0][SW-1:0] = sl_sum_s[SW-1:0];
        for (int k = 1; k < STAGES; k++) begin
            res_nxt_s[k]              = res_r[k-1];
            res_nxt_s[k][k*SW +: SW]  = sl_sum_s[k*SW +: SW];
        end
    end

    // Stall chain: a stage may move if every stage above it can absorb a beat
    always_comb begin
        logic go;
        go     = out_ready;
        adv_s  = '0;
        load_s = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv_s[k] = v_r[k] & go;
            go       = ~v_r[k] | go;
        end
        in_ready_s = ~rst & (~v_r[0] | adv_s[0]);
        load_s[0]  = in_valid & in_ready_s;
        for (int k = 1; k < STAGES; k++) begin
            load_s[k] = adv_s[k-1];
        end
    end

    // Stage valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    v_r[k] <= 1'b1;
                end else if (adv_s[k]) begin
                    v_r[k] <= 1'b0;
                end else begin
                    v_r[k] <= v_r[k];
                end
            end
        end
    end

    // Stage data: skewed operands, deskewed result, carry, top-slice overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= '0;
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    a_r[k]     <= a_in_s[k];
                    b_r[k]     <= b_in_s[k];
                    res_r[k]   <= res_nxt_s[k];
                    carry_r[k] <= sl_co_s[k];
                end
            end
            if (load_s[LAST]) begin
                ovf_r <= sl_cmsb_s[LAST] ^ sl_co_s[LAST];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_r[LAST];
    assign sum       = res_r[LAST];
    assign cout      = carry_r[LAST];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub at three width/depth points.
module tb_pipelined_adder_sub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    localparam int W [3] = '{16, 8, 32};
    localparam int S [3] = '{4, 1, 8};

    localparam logic [15:0] DA   [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h00FF, 16'h0010, 16'h8000};
    localparam logic [15:0] DB   [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0000, 16'h0001, 16'h8000};
    localparam logic        DCIN [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic        DSUB [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] DSUM [8] = '{16'h5555, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0100, 16'h000E, 16'h0000};
    localparam logic        DCO  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic        DOV  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;

    logic        in_valid_d  [3];
    logic        out_ready_d [3];
    logic        cin_d       [3];
    logic        sub_d       [3];
    logic [31:0] a_d         [3];
    logic [31:0] b_d         [3];
    logic        in_ready_d  [3];
    logic        out_valid_d [3];
    logic        cout_d      [3];
    logic        ovf_d       [3];
    logic [31:0] sum_d       [3];
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [31:0] sum2;

    exp_t sb [3][$];
    int tests  = 0;
    int failed = 0;

    assign sum_d[0] = {16'd0, sum0};
    assign sum_d[1] = {24'd0, sum1};
    assign sum_d[2] = sum2;

    pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d[0]), .in_ready(in_ready_d[0]),
        .a(a_d[0][15:0]), .b(b_d[0][15:0]), .cin(cin_d[0]), .sub(sub_d[0]),
        .out_valid(out_valid_d[0]), .out_ready(out_ready_d[0]),
        .sum(sum0), .cout(cout_d[0]), .ovf(ovf_d[0])
    );

    pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d[1]), .in_ready(in_ready_d[1]),
        .a(a_d[1][7:0]), .b(b_d[1][7:0]), .cin(cin_d[1]), .sub(sub_d[1]),
        .out_valid(out_valid_d[1]), .out_ready(out_ready_d[1]),
        .sum(sum1), .cout(cout_d[1]), .ovf(ovf_d[1])
    );

    pipelined_adder_sub #(.WIDTH(32), .STAGES(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d[2]), .in_ready(in_ready_d[2]),
        .a(a_d[2]), .b(b_d[2]), .cin(cin_d[2]), .sub(sub_d[2]),
        .out_valid(out_valid_d[2]), .out_ready(out_ready_d[2]),
        .sum(sum2), .cout(cout_d[2]), .ovf(ovf_d[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: plain wide addition, overflow from operand/result signs
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic c, input logic s);
        exp_t        e;
        logic [63:0] m, aa, bb, full;
        m    = {32'd0, wmask(w)};
        aa   = {32'd0, av} & m;
        bb   = (s ? ~{32'd0, bv} : {32'd0, bv}) & m;
        full = aa + bb + {63'd0, (s ? ~c : c)};
        e.sum  = full[31:0] & m[31:0];
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return e;
    endfunction

    task automatic mon(input int i);
        exp_t        e;
        logic [31:0] m;
        m = wmask(W[i]);
        if (rst_q) begin
            check_eq($sformatf("d%0d_reset_out", i),
                     64'({out_valid_d[i], cout_d[i], ovf_d[i], sum_d[i] & m}), 64'd0);
        end
        if (rst) begin
            check_eq($sformatf("d%0d_in_ready_rst", i), 64'(in_ready_d[i]), 64'd0);
            sb[i].delete();
        end else begin
            check_eq($sformatf("d%0d_in_ready", i), 64'(in_ready_d[i]),
                     64'((sb[i].size() < S[i]) || out_ready_d[i]));
            if (out_valid_d[i]) begin
                if (sb[i].size() == 0) begin
                    check_eq($sformatf("d%0d_spurious_out", i), 64'(out_valid_d[i]), 64'd0);
                end else begin
                    e = sb[i][0];
                    check_eq($sformatf("d%0d_result", i),
                             64'({cout_d[i], ovf_d[i], sum_d[i] & m}),
                             64'({e.cout, e.ovf, e.sum}));
                    if (out_ready_d[i]) void'(sb[i].pop_front());
                end
            end
            if (in_valid_d[i] && in_ready_d[i]) begin
                sb[i].push_back(model(W[i], a_d[i], b_d[i], cin_d[i], sub_d[i]));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon(i);
    end

    // Hold one beat until accepted; returns one step after the accepting edge
    task automatic send(input int i, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic s);
        int n;
        in_valid_d[i] = 1'b1;
        a_d[i] = av;
        b_d[i] = bv;
        cin_d[i] = c;
        sub_d[i] = s;
        n = 0;
        @(negedge clk);
        while (!in_ready_d[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("d%0d_accept_timeout", i), 64'(n >= 300), 64'd0);
        @(posedge clk);
        #1;
        in_valid_d[i] = 1'b0;
    endtask

    task automatic wait_empty(input int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check_eq($sformatf("d%0d_drain_timeout", i), 64'(n >= 1000), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] m);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return m;
            2:       return m >> 1;
            3:       return m & ~(m >> 1);
            default: return $urandom & m;
        endcase
    endfunction

    task automatic rand_stream(input int i, input int cnt);
        logic [31:0] m;
        m = wmask(W[i]);
        for (int k = 0; k < cnt; k++) begin
            send(i, pick(m), pick(m), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid_d[i]  = 1'b0;
            out_ready_d[i] = 1'b1;
            cin_d[i]       = 1'b0;
            sub_d[i]       = 1'b0;
            a_d[i]         = 32'd0;
            b_d[i]         = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with exact latency on the 16/4 instance
        for (int k = 0; k < 8; k++) begin
            send(0, {16'd0, DA[k]}, {16'd0, DB[k]}, DCIN[k], DSUB[k]);
            repeat (S[0] - 1) begin
                @(negedge clk);
                check_eq($sformatf("dir%0d_early_valid", k), 64'(out_valid_d[0]), 64'd0);
            end
            @(negedge clk);
            check_eq($sformatf("dir%0d_value", k),
                     64'({out_valid_d[0], cout_d[0], ovf_d[0], sum0}),
                     64'({1'b1, DCO[k], DOV[k], DSUM[k]}));
            @(posedge clk);
            #1;
        end

        // Back-to-back stream with a four-cycle consumer stall
        fork
            for (int k = 0; k < 8; k++) send(0, 32'(k), 32'(k), 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready_d[0] = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready_d[0] = 1'b1;
            end
        join
        wait_empty(0);

        // Reset with three beats in flight, then confirm recovery
        out_ready_d[0] = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 32'h0100 + 32'(k), 32'h0003, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready_d[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(0, 32'h0042, 32'h0001, 1'b1, 1'b1);
        wait_empty(0);

        // Random traffic with random backpressure on 8/1 and 32/8
        fork
            rand_stream(1, 80);
            rand_stream(2, 80);
            begin
                repeat (200) begin
                    @(posedge clk);
                    #1;
                    out_ready_d[1] = ($urandom_range(0, 2) != 0);
                    out_ready_d[2] = ($urandom_range(0, 2) != 0);
                end
                out_ready_d[1] = 1'b1;
                out_ready_d[2] = 1'b1;
            end
        join
        out_ready_d[1] = 1'b1;
        out_ready_d[2] = 1'b1;
        wait_empty(1);
        wait_empty(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
